// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path: frame geometry,
// RGB444 pixel packing and the capture FSM encoding.
package cam_pkg;

   localparam int FRAME_W = 640;
   localparam int FRAME_H = 480;
   localparam int HALF_W  = 320;
   localparam int HALF_H  = 240;
   localparam int RGB_W   = 12;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_ACTIVE = 2'd2
   } cam_state_e;

   // The sensor sends xxxxRRRR then GGGGBBBB for each RGB444 pixel.
   function automatic rgb444_t pack_rgb444(input logic [3:0] first_lo,
                                           input logic [7:0] second);
      rgb444_t px;
      px.r = first_lo;
      px.g = second[7:4];
      px.b = second[3:0];
      return px;
   endfunction

endpackage

// File: rtl/cam_byte_pair.sv
// Pairs consecutive camera bytes into one RGB444 pixel; a pixel is presented
// combinationally in the cycle its second byte is on the registered bus.
module cam_byte_pair
   import cam_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       byte_valid,
   input  logic [7:0] byte_in,
   output logic       pix_valid,
   output rgb444_t    pix_data,
   output logic       pending
);

   logic [3:0] first_q, first_d;
   logic       have_first_q, have_first_d;

   // Any gap in byte_valid drops a half-received pixel.
   always_comb begin
      first_d      = first_q;
      have_first_d = 1'b0;
      pix_valid    = 1'b0;
      if (!clear && byte_valid) begin
         if (have_first_q) begin
            pix_valid = 1'b1;
         end else begin
            first_d      = byte_in[3:0];
            have_first_d = 1'b1;
         end
      end
   end

   assign pix_data = pack_rgb444(first_q, byte_in);
   assign pending  = have_first_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_q      <= '0;
         have_first_q <= 1'b0;
      end else begin
         first_q      <= first_d;
         have_first_q <= have_first_d;
      end
   end

endmodule

// File: rtl/cam_capture.sv
// Camera frame capture: registers the sensor bus, runs the frame FSM, tracks
// line/pixel position and emits RGB444 pixel writes with optional 2:1 decimation.
module cam_capture
   import cam_pkg::*;
#(
   parameter int CAM_DATA_WIDTH = 12,
   parameter int CAM_LINE       = 9,
   parameter int CAM_PIXEL      = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic                      i_resize,
   input  logic                      i_vsync,
   input  logic                      i_href,
   input  logic [7:0]                i_d,
   output logic                      o_we,
   output logic [CAM_DATA_WIDTH-1:0] o_data,
   output logic [CAM_LINE-1:0]       o_line,
   output logic [CAM_PIXEL-1:0]      o_pixel,
   output logic [CAM_LINE-1:0]       o_imag_depth,
   output logic [CAM_PIXEL-1:0]      o_imag_width,
   output logic                      o_imag_resized,
   output logic                      o_frame_done,
   output logic                      o_err
);

   localparam logic [CAM_PIXEL-1:0] PIX_MAX   = CAM_PIXEL'(FRAME_W);
   localparam logic [CAM_LINE-1:0]  LINE_MAX  = CAM_LINE'(FRAME_H);
   localparam logic [CAM_PIXEL-1:0] PIX_HALF  = CAM_PIXEL'(HALF_W);
   localparam logic [CAM_LINE-1:0]  LINE_HALF = CAM_LINE'(HALF_H);

   logic       vsync_q, vsync_qq, href_q, href_qq;
   logic [7:0] d_q;

   cam_state_e state_q, state_d;
   logic       cap_en_q, cap_en_d;
   logic       resize_q, resize_d;

   logic [CAM_PIXEL-1:0]      pix_cnt_q, pix_cnt_d;
   logic [CAM_LINE-1:0]       line_cnt_q, line_cnt_d;
   logic                      we_q, we_d;
   logic [CAM_DATA_WIDTH-1:0] data_q, data_d;
   logic [CAM_LINE-1:0]       line_q, line_d;
   logic [CAM_PIXEL-1:0]      pixel_q, pixel_d;
   logic                      frame_done_q, frame_done_d;
   logic                      err_q, err_d;
   logic [CAM_LINE-1:0]       depth_q, depth_d;
   logic [CAM_PIXEL-1:0]      width_q, width_d;
   logic                      resized_q, resized_d;

   logic    vsync_rise, vsync_fall, href_fall, active;
   logic    byte_valid, pair_clear, pix_valid, pair_pending;
   logic    in_range, keep;
   rgb444_t pix_data;

   assign vsync_rise = vsync_q & ~vsync_qq;
   assign vsync_fall = ~vsync_q & vsync_qq;
   assign href_fall  = ~href_q & href_qq;
   assign active     = (state_q == ST_ACTIVE);
   // Nothing is captured on the frame-end edge itself.
   assign byte_valid = active & href_q & ~vsync_rise;
   assign pair_clear = ~active | vsync_rise;

   cam_byte_pair u_pair (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (pair_clear),
      .byte_valid(byte_valid),
      .byte_in   (d_q),
      .pix_valid (pix_valid),
      .pix_data  (pix_data),
      .pending   (pair_pending)
   );

   assign in_range = (pix_cnt_q < PIX_MAX) && (line_cnt_q < LINE_MAX);
   assign keep     = ~resize_q | (~pix_cnt_q[0] & ~line_cnt_q[0]);

   always_comb begin
      state_d      = state_q;
      cap_en_d     = cap_en_q;
      resize_d     = resize_q;
      pix_cnt_d    = pix_cnt_q;
      line_cnt_d   = line_cnt_q;
      we_d         = 1'b0;
      data_d       = data_q;
      line_d       = line_q;
      pixel_d      = pixel_q;
      frame_done_d = 1'b0;
      err_d        = err_q;
      depth_d      = depth_q;
      width_d      = width_q;
      resized_d    = resized_q;

      case (state_q)
         ST_IDLE: begin
            if (vsync_q) state_d = ST_SYNC;
         end
         ST_SYNC: begin
            if (vsync_fall) begin
               if (enable) begin
                  state_d    = ST_ACTIVE;
                  cap_en_d   = enable;
                  resize_d   = i_resize;
                  pix_cnt_d  = '0;
                  line_cnt_d = '0;
                  depth_d    = i_resize ? LINE_HALF : LINE_MAX;
                  width_d    = i_resize ? PIX_HALF  : PIX_MAX;
                  resized_d  = i_resize;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_ACTIVE: begin
            if (pix_valid) begin
               if (cap_en_q && in_range && keep) begin
                  we_d    = 1'b1;
                  data_d  = CAM_DATA_WIDTH'(pix_data);
                  line_d  = resize_q ? (line_cnt_q >> 1) : line_cnt_q;
                  pixel_d = resize_q ? (pix_cnt_q >> 1)  : pix_cnt_q;
               end
               if (pix_cnt_q != PIX_MAX) pix_cnt_d = pix_cnt_q + 1'b1;
            end
            // Line end is applied before a coincident frame end.
            if (href_fall) begin
               if (pair_pending) err_d = 1'b1;
               if ((pix_cnt_q != '0) && (line_cnt_q != LINE_MAX))
                  line_cnt_d = line_cnt_q + 1'b1;
               pix_cnt_d = '0;
            end
            if (vsync_rise) begin
               frame_done_d = 1'b1;
               if (href_q) err_d = 1'b1;
               state_d = ST_SYNC;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q      <= 1'b0;
         vsync_qq     <= 1'b0;
         href_q       <= 1'b0;
         href_qq      <= 1'b0;
         d_q          <= '0;
         state_q      <= ST_IDLE;
         cap_en_q     <= 1'b0;
         resize_q     <= 1'b0;
         pix_cnt_q    <= '0;
         line_cnt_q   <= '0;
         we_q         <= 1'b0;
         data_q       <= '0;
         line_q       <= '0;
         pixel_q      <= '0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
         depth_q      <= LINE_MAX;
         width_q      <= PIX_MAX;
         resized_q    <= 1'b0;
      end else begin
         vsync_q      <= i_vsync;
         vsync_qq     <= vsync_q;
         href_q       <= i_href;
         href_qq      <= href_q;
         d_q          <= i_d;
         state_q      <= state_d;
         cap_en_q     <= cap_en_d;
         resize_q     <= resize_d;
         pix_cnt_q    <= pix_cnt_d;
         line_cnt_q   <= line_cnt_d;
         we_q         <= we_d;
         data_q       <= data_d;
         line_q       <= line_d;
         pixel_q      <= pixel_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
         depth_q      <= depth_d;
         width_q      <= width_d;
         resized_q    <= resized_d;
      end
   end

   assign o_we           = we_q;
   assign o_data         = data_q;
   assign o_line         = line_q;
   assign o_pixel        = pixel_q;
   assign o_frame_done   = frame_done_q;
   assign o_err          = err_q;
   assign o_imag_depth   = depth_q;
   assign o_imag_width   = width_q;
   assign o_imag_resized = resized_q;

endmodule
